// File: rtl/rr_resource_arbiter_if.sv
// Requester-side bundle for rr_resource_arbiter.
// The master modport is the requester side. The slave modport is the arbiter.
interface rr_resource_arbiter_if #(
  parameter int unsigned N = 4
);
  localparam int unsigned IdW = $clog2(N);

  logic [N-1:0]   req;
  logic           done;
  logic [N-1:0]   gnt;
  logic           gnt_valid;
  logic [IdW-1:0] gnt_id;
  logic           timeout;

  modport master (
    output req,
    output done,
    input  gnt,
    input  gnt_valid,
    input  gnt_id,
    input  timeout
  );

  modport slave (
    input  req,
    input  done,
    output gnt,
    output gnt_valid,
    output gnt_id,
    output timeout
  );
endinterface

// File: rtl/rr_resource_arbiter.sv
// Round-robin arbiter for one single-user resource.
// It uses a grant/done handshake.
// A hold limit forces release of an owner that never signals done.
module rr_resource_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned MAX_HOLD = 16
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  rr_resource_arbiter_if.slave  bus
);

  localparam int unsigned IdW = $clog2(N);

  typedef enum logic {StIdle, StGrant} state_e;

  state_e         state_q, state_d;
  logic [IdW-1:0] ptr_q, ptr_d;
  logic [IdW-1:0] owner_q, owner_d;
  logic [7:0]     hold_cnt_q, hold_cnt_d;
  logic [N-1:0]   gnt_q, gnt_d;
  logic           gnt_valid_q, gnt_valid_d;
  logic [IdW-1:0] gnt_id_q, gnt_id_d;
  logic           timeout_q, timeout_d;

  logic [IdW-1:0] win;
  logic           forced_rel;

  // Registers all state and outputs; reset is synchronous.
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q     <= StIdle;
      ptr_q       <= '0;
      owner_q     <= '0;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      owner_q     <= owner_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      timeout_q   <= timeout_d;
    end
  end

  // Picks the first requester at or after ptr, wrapping modulo N.
  always_comb begin
    int unsigned idx;
    logic        found;
    win   = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && bus.req[IdW'(idx)]) begin
        found = 1'b1;
        win   = IdW'(idx);
      end
    end
  end

  // Computes next state; release priority is done, then abandon, then hold limit.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    owner_d    = owner_q;
    hold_cnt_d = hold_cnt_q;
    forced_rel = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (|bus.req) begin
          state_d    = StGrant;
          owner_d    = win;
          hold_cnt_d = '0;
        end
      end
      StGrant: begin
        if (bus.done || !bus.req[owner_q] || (hold_cnt_q == 8'(MAX_HOLD - 1))) begin
          state_d    = StIdle;
          ptr_d      = (owner_q == IdW'(N - 1)) ? '0 : owner_q + 1'b1;
          forced_rel = !bus.done && bus.req[owner_q];
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Derives the next registered outputs from the next state.
  always_comb begin
    gnt_d       = '0;
    gnt_valid_d = 1'b0;
    gnt_id_d    = '0;
    timeout_d   = forced_rel;
    if (state_d == StGrant) begin
      gnt_d[owner_d] = 1'b1;
      gnt_valid_d    = 1'b1;
      gnt_id_d       = owner_d;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.gnt_id    = gnt_id_q;
  assign bus.timeout   = timeout_q;

endmodule

// File: tb/tb_rr_resource_arbiter.sv
// Directed bench for rr_resource_arbiter with N=4 and MAX_HOLD=4.
// Each row drives one cycle of inputs.
// It also queues the outputs expected after the following clock edge.
module tb_rr_resource_arbiter;
  localparam int N        = 4;
  localparam int MAX_HOLD = 4;

  logic clk = 1'b0;
  logic reset_n;

  rr_resource_arbiter_if #(.N(N)) bus ();

  rr_resource_arbiter #(
    .N        (N),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk_i    (clk),
    .reset_ni (reset_n),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] gnt;
    logic       to;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;
  int   row_num  = 0;

  task automatic check(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s row=%0d actual=%0h required=%0h", name, row, act, req);
    end
  endtask

  // Monitor: the bench pops one expectation after each clock edge that has one pending.
  always @(posedge clk) begin
    exp_t e;
    int   eid;
    #2;
    if (exp_q.size() > 0) begin
      e   = exp_q.pop_front();
      eid = 0;
      for (int b = 0; b < N; b++) if (e.gnt[b]) eid = b;
      row_num++;
      check("gnt", row_num, 32'(bus.gnt), 32'(e.gnt));
      check("gnt_valid", row_num, 32'(bus.gnt_valid), 32'(|e.gnt));
      check("gnt_id", row_num, 32'(bus.gnt_id), 32'(eid));
      check("timeout", row_num, 32'(bus.timeout), 32'(e.to));
    end
  end

  task automatic row(input logic rst_n, input logic [3:0] req, input logic done,
                     input logic [3:0] egnt, input logic eto);
    @(negedge clk);
    reset_n  = rst_n;
    bus.req  = req;
    bus.done = done;
    exp_q.push_back('{gnt: egnt, to: eto});
  endtask

  initial begin
    reset_n  = 1'b0;
    bus.req  = '0;
    bus.done = 1'b0;

    // Reset followed by a single request.
    row(0, 4'b0000, 0, 4'b0000, 0);
    row(0, 4'b0010, 0, 4'b0000, 0);
    row(1, 4'b0010, 0, 4'b0010, 0);
    row(1, 4'b0010, 0, 4'b0010, 0);
    row(1, 4'b0010, 1, 4'b0000, 0);
    row(1, 4'b0000, 0, 4'b0000, 0);

    // Rotation from ptr=0 with all requesting and done on the first grant cycle.
    row(0, 4'b0000, 0, 4'b0000, 0);
    row(1, 4'b1111, 0, 4'b0001, 0);
    row(1, 4'b1111, 1, 4'b0000, 0);
    row(1, 4'b1111, 0, 4'b0010, 0);
    row(1, 4'b1111, 1, 4'b0000, 0);
    row(1, 4'b1111, 0, 4'b0100, 0);
    row(1, 4'b1111, 1, 4'b0000, 0);
    row(1, 4'b1111, 0, 4'b1000, 0);
    row(1, 4'b1111, 1, 4'b0000, 0);
    row(1, 4'b1111, 0, 4'b0001, 0);
    row(1, 4'b1111, 1, 4'b0000, 0);
    row(1, 4'b0000, 0, 4'b0000, 0);

    // Timeout: there are 4 grant cycles, then a timeout cycle, then a regrant.
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0000, 1);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(1, 4'b0100, 0, 4'b0000, 1);
    // ptr is 3, so requester 3 beats requester 2.
    row(1, 4'b1100, 0, 4'b1000, 0);

    // Done arrives on the 4th grant cycle, so this is a normal release.
    row(1, 4'b1100, 0, 4'b1000, 0);
    row(1, 4'b1100, 0, 4'b1000, 0);
    row(1, 4'b1100, 0, 4'b1000, 0);
    row(1, 4'b1100, 1, 4'b0000, 0);

    // Abandon: requester 2 drops its request on its 2nd grant cycle.
    row(1, 4'b1100, 0, 4'b0100, 0);
    row(1, 4'b1100, 0, 4'b0100, 0);
    row(1, 4'b1000, 0, 4'b0000, 0);
    // ptr has advanced to 3.
    row(1, 4'b1001, 0, 4'b1000, 0);
    row(1, 4'b1001, 1, 4'b0000, 0);

    // Move ptr to 2, then reset during the grant of requester 2.
    row(1, 4'b0010, 0, 4'b0010, 0);
    row(1, 4'b0010, 1, 4'b0000, 0);
    row(1, 4'b0100, 0, 4'b0100, 0);
    row(0, 4'b0100, 0, 4'b0000, 0);
    row(1, 4'b1111, 0, 4'b0001, 0);
    row(1, 4'b1111, 1, 4'b0000, 0);
    // Done is ignored in IDLE.
    row(1, 4'b0000, 1, 4'b0000, 0);
    row(1, 4'b0000, 0, 4'b0000, 0);

    @(negedge clk);
    @(negedge clk);
    check("queue_drained", 0, 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
